phase_shift_ctrl: RTL and testbench
===================================

# phase_shift_ctrl

Configuration sequencer for the two-channel `digitalPhaseshifter` in the ETROC2 readout. It runs in the clk40 domain and owns the `clockDelay1/2` and `pulseWidth1/2` buses. It applies slow-control settings only on an explicit update request and hands the shifter two clk40 cycles to settle after each change. It also provides an automated delay-scan engine for phase calibration, which walks one channel's delay through a range, dwells at each step, then restores the original setting.

## Interface
Parameters:
- `DWELL_W`, default 8: width of the per-step dwell counter.

Ports:
- `clk40` in 1: 40 MHz system clock, the only clock.
- `reset` in 1: synchronous, active-high reset.
- `cfgDelay1`, `cfgDelay2` in 5: requested delay per channel, in clk1280 ticks.
- `cfgWidth1`, `cfgWidth2` in 5: requested pulse width per channel.
- `cfgUpdate` in 1: one-cycle pulse requesting that all four cfg values be applied.
- `scanStart` in 1: one-cycle pulse that starts a scan.
- `scanAbort` in 1: level or pulse that terminates a scan.
- `scanChannel` in 1: 0 scans channel 1, 1 scans channel 2.
- `scanFirst`, `scanLast` in 5: first and last delay code of the scan.
- `scanDwell` in DWELL_W: clk40 cycles held at each step after settling.
- `clockDelay1`, `clockDelay2` out 5: registered drive to the shifter.
- `pulseWidth1`, `pulseWidth2` out 5: registered drive to the shifter.
- `updateDone` out 1: pulse, cfg update applied and settled.
- `stepReady` out 1: pulse, current scan step has settled.
- `scanBusy` out 1: high from the first scan state until scan exit.
- `scanDone` out 1: pulse, scan finished or aborted and setting restored.

## Operation
- Reset values: delays 0, widths 16, all flags 0, FSM in IDLE, pending flags cleared. Reset mid-scan drops the scan and does not restore.
- FSM states: IDLE, APPLY, SETTLE, SCAN_SET, SCAN_SETTLE, SCAN_DWELL, SCAN_END.
- IDLE with `cfgUpdate`: go to APPLY and load all four outputs from cfg.
- APPLY goes to SETTLE. After SETTLE_CYCLES, pulse `updateDone` and return to IDLE.
- IDLE with `scanStart`:
  - Save the scanned channel's current delay and set step = `scanFirst`.
  - SCAN_SET loads the step into the scanned channel's delay.
  - SCAN_SETTLE waits SETTLE_CYCLES, then pulses `stepReady` and enters SCAN_DWELL.
  - SCAN_DWELL waits `scanDwell` cycles; a value of 0 is treated as 1.
  - If step == `scanLast`, go to SCAN_END. Otherwise set step = (step+1) mod 32 and go to SCAN_SET.
- Step arithmetic is 5-bit wrap-around:
  - Step count = ((`scanLast` − `scanFirst`) mod 32) + 1.
  - `scanFirst` == `scanLast` gives exactly one step.
  - First=30, Last=1 visits 30, 31, 0, 1.
- SCAN_END restores the saved delay and pulses `scanDone` for one cycle. It then returns to IDLE, or to APPLY if an update is pending.
- During a scan, the scanned channel's pulse width and the other channel are untouched.
- `scanAbort` in any SCAN_* state: the next state is SCAN_END. No further `stepReady` is issued, even if it was due in the same cycle.
- `cfgUpdate` during a scan or SETTLE sets `pendUpdate`. The cfg values are sampled when APPLY executes, not when the request arrives.
- `cfgUpdate` and `scanStart` in the same IDLE cycle: the update goes first. `scanStart` is latched into `pendScan`, and the scan starts the cycle after `updateDone`.
- `scanStart` while a scan is busy is ignored.
- `scanFirst`, `scanLast`, `scanDwell` and `scanChannel` are sampled once, at scan start.

## Timing
- `cfgUpdate` sampled at edge k: outputs change at edge k+1, `updateDone` is high after edge k+3, and IDLE is reached at edge k+3.
- `scanStart` sampled at edge k:
  - Delay = `scanFirst` at edge k+1 and `scanBusy` rises at k+1.
  - `stepReady` is high for the cycle after edge k+3.
  - The next step loads at edge k+3+D+1, where D is the effective dwell.
- Per-step period = 1 + SETTLE_CYCLES + D cycles.
- `scanDone` is high for one cycle at the SCAN_END edge, and `scanBusy` falls on the same edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `PSCTRL_SCAN_EN` defined: the scan engine is compiled in as described above.
- Undefined: the SCAN_* states, step register and save register are removed.
  - `scanStart` and `scanAbort` are ignored.
  - `scanBusy`, `stepReady` and `scanDone` are tied to 0.
  - The update path is unchanged.

## Structure
- Package `psctrl_pkg` holds:
  - `DELAY_W=5`, `SETTLE_CYCLES=2`, `RST_DELAY=0`, `RST_WIDTH=16`.
  - The FSM state enum typedef.
- Sub-module `psctrl_timer`: a loadable down-counter shared by SETTLE and DWELL, with a `load`/`value`/`expired` interface.

## Test plan
- Reset, then `cfgUpdate` with delay1=3, width1=15, delay2=29, width2=31 → outputs update at k+1 and `updateDone` is high at k+3.
- Scan ch1 with First=2, Last=4, Dwell=5, original delay 7 → delay sequence 2, 3, 4, three `stepReady` pulses 8 cycles apart, then delay returns to 7 with `scanDone`.
- Scan ch2 with First=30, Last=1 → four steps 30, 31, 0, 1. Channel 1 outputs are unchanged throughout.
- Assert `scanAbort` during the second step's dwell → exactly one more cycle of scan state, then restore and `scanDone`, with no third `stepReady`.
- `cfgUpdate` mid-scan, then `cfgUpdate` and `scanStart` together in IDLE → the pending update is applied after `scanDone`, and in the simultaneous case the update completes before the scan begins.
- Assert `reset` during SCAN_DWELL → next cycle delays 0, widths 16, `scanBusy` 0, no `scanDone`.

Source files
------------

// File: rtl/psctrl_pkg.sv
// psctrl_pkg: shared widths, reset values and FSM encoding for phase_shift_ctrl.
package psctrl_pkg;

  localparam int unsigned DELAY_W       = 5;
  localparam int unsigned SETTLE_CYCLES = 2;

  localparam logic [DELAY_W-1:0] RST_DELAY = 5'd0;
  localparam logic [DELAY_W-1:0] RST_WIDTH = 5'd16;

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StApply      = 3'd1,
    StSettle     = 3'd2,
    StScanSet    = 3'd3,
    StScanSettle = 3'd4,
    StScanDwell  = 3'd5,
    StScanEnd    = 3'd6
  } psctrl_state_e;

  // Scan steps wrap modulo 2**DELAY_W, so 31 is followed by 0.
  function automatic logic [DELAY_W-1:0] step_next(input logic [DELAY_W-1:0] s);
    return s + 1'b1;
  endfunction

endpackage

// File: rtl/psctrl_timer.sv
// psctrl_timer: loadable down-counter shared by the settle and dwell phases.
// expired_o is high during the last counted cycle, so a load of N lets the
// owner leave its state N cycles after the load edge.
module psctrl_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load wins over counting; the counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q[Width-1:1] == '0);

endmodule

// File: rtl/phase_shift_ctrl.sv
// phase_shift_ctrl: clk40 configuration sequencer for the two-channel phase shifter.
// Settings are applied only on cfgUpdate and given SETTLE_CYCLES to settle.
// Define PSCTRL_SCAN_EN to build in the delay-scan engine; without it the scan
// inputs are ignored and scanBusy/stepReady/scanDone read 0.
module phase_shift_ctrl
  import psctrl_pkg::*;
#(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk40,
  input  logic               reset,
  input  logic [DELAY_W-1:0] cfgDelay1,
  input  logic [DELAY_W-1:0] cfgDelay2,
  input  logic [DELAY_W-1:0] cfgWidth1,
  input  logic [DELAY_W-1:0] cfgWidth2,
  input  logic               cfgUpdate,
  input  logic               scanStart,
  input  logic               scanAbort,
  input  logic               scanChannel,
  input  logic [DELAY_W-1:0] scanFirst,
  input  logic [DELAY_W-1:0] scanLast,
  input  logic [DWELL_W-1:0] scanDwell,
  output logic [DELAY_W-1:0] clockDelay1,
  output logic [DELAY_W-1:0] clockDelay2,
  output logic [DELAY_W-1:0] pulseWidth1,
  output logic [DELAY_W-1:0] pulseWidth2,
  output logic               updateDone,
  output logic               stepReady,
  output logic               scanBusy,
  output logic               scanDone
);

  localparam int unsigned TmrW = (DWELL_W > 2) ? DWELL_W : 2;

  psctrl_state_e      state_q, state_d;
  logic [DELAY_W-1:0] delay1_q, delay1_d;
  logic [DELAY_W-1:0] delay2_q, delay2_d;
  logic [DELAY_W-1:0] width1_q, width1_d;
  logic [DELAY_W-1:0] width2_q, width2_d;
  logic               pend_upd_q, pend_upd_d;
  logic               upd_done_q, upd_done_d;

  logic               tmr_load;
  logic [TmrW-1:0]    tmr_val;
  logic               tmr_expired;

  psctrl_timer #(
    .Width (TmrW)
  ) u_timer (
    .clk_i     (clk40),
    .rst_i     (reset),
    .load_i    (tmr_load),
    .value_i   (tmr_val),
    .expired_o (tmr_expired)
  );

`ifdef PSCTRL_SCAN_EN
  logic [DELAY_W-1:0] step_q, step_d;
  logic [DELAY_W-1:0] saved_q, saved_d;
  logic [DELAY_W-1:0] first_q, first_d;
  logic [DELAY_W-1:0] last_q, last_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               ch_q, ch_d;
  logic               pend_scan_q, pend_scan_d;
  logic               busy_q, busy_d;
  logic               step_rdy_q, step_rdy_d;
  logic               done_q, done_d;

  logic               scan_accept;
  logic               start_ch;
  logic [DELAY_W-1:0] start_first;
  logic [TmrW-1:0]    dwell_eff;

  // A start is accepted only outside the scan states and when none is queued;
  // the scan parameters are captured on that same cycle.
  assign scan_accept = scanStart && !pend_scan_q &&
                       ((state_q == StIdle) || (state_q == StApply) || (state_q == StSettle));
  assign start_ch    = scan_accept ? scanChannel : ch_q;
  assign start_first = scan_accept ? scanFirst : first_q;
  assign dwell_eff   = (dwell_q == '0) ? TmrW'(1) : TmrW'(dwell_q);
`else
  logic unused_scan;
  assign unused_scan = ^{scanStart, scanAbort, scanChannel, scanFirst, scanLast, scanDwell};
`endif

  // Next-state logic: sequencing, output loads, timer control and request queuing.
  always_comb begin
    state_d    = state_q;
    delay1_d   = delay1_q;
    delay2_d   = delay2_q;
    width1_d   = width1_q;
    width2_d   = width2_q;
    pend_upd_d = pend_upd_q;
    upd_done_d = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
`ifdef PSCTRL_SCAN_EN
    step_d      = step_q;
    saved_d     = saved_q;
    first_d     = first_q;
    last_d      = last_q;
    dwell_d     = dwell_q;
    ch_d        = ch_q;
    pend_scan_d = pend_scan_q;
    busy_d      = busy_q;
    step_rdy_d  = 1'b0;
    done_d      = 1'b0;

    if (scan_accept) begin
      ch_d    = scanChannel;
      first_d = scanFirst;
      last_d  = scanLast;
      dwell_d = scanDwell;
      // Update traffic has priority; the scan waits for the FSM to return to idle.
      if ((state_q != StIdle) || cfgUpdate) begin
        pend_scan_d = 1'b1;
      end
    end
`endif

    // Update requests outside idle are replayed once the current activity ends.
    if (cfgUpdate && (state_q != StIdle)) begin
      pend_upd_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cfgUpdate) begin
          state_d = StApply;
        end
`ifdef PSCTRL_SCAN_EN
        else if (scan_accept || pend_scan_q) begin
          pend_scan_d = 1'b0;
          saved_d     = start_ch ? delay2_q : delay1_q;
          step_d      = start_first;
          state_d     = StScanSet;
        end
`endif
      end

      // cfg values are sampled here, not when the request arrived.
      StApply: begin
        delay1_d = cfgDelay1;
        delay2_d = cfgDelay2;
        width1_d = cfgWidth1;
        width2_d = cfgWidth2;
        tmr_load = 1'b1;
        tmr_val  = TmrW'(SETTLE_CYCLES);
        state_d  = StSettle;
      end

      StSettle: begin
        if (tmr_expired) begin
          upd_done_d = 1'b1;
          if (pend_upd_d) begin
            pend_upd_d = 1'b0;
            state_d    = StApply;
          end else begin
            state_d = StIdle;
          end
        end
      end

`ifdef PSCTRL_SCAN_EN
      StScanSet: begin
        busy_d = 1'b1;
        if (scanAbort) begin
          state_d = StScanEnd;
        end else begin
          if (ch_q) begin
            delay2_d = step_q;
          end else begin
            delay1_d = step_q;
          end
          tmr_load = 1'b1;
          tmr_val  = TmrW'(SETTLE_CYCLES);
          state_d  = StScanSettle;
        end
      end

      // Abort outranks a stepReady that would fall due on the same edge.
      StScanSettle: begin
        if (scanAbort) begin
          state_d = StScanEnd;
        end else if (tmr_expired) begin
          step_rdy_d = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = dwell_eff;
          state_d    = StScanDwell;
        end
      end

      StScanDwell: begin
        if (scanAbort) begin
          state_d = StScanEnd;
        end else if (tmr_expired) begin
          if (step_q == last_q) begin
            state_d = StScanEnd;
          end else begin
            step_d  = step_next(step_q);
            state_d = StScanSet;
          end
        end
      end

      StScanEnd: begin
        if (ch_q) begin
          delay2_d = saved_q;
        end else begin
          delay1_d = saved_q;
        end
        done_d = 1'b1;
        busy_d = 1'b0;
        if (pend_upd_d) begin
          pend_upd_d = 1'b0;
          state_d    = StApply;
        end else begin
          state_d = StIdle;
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset mid-scan drops the scan without restoring.
  always_ff @(posedge clk40) begin
    if (reset) begin
      state_q    <= StIdle;
      delay1_q   <= RST_DELAY;
      delay2_q   <= RST_DELAY;
      width1_q   <= RST_WIDTH;
      width2_q   <= RST_WIDTH;
      pend_upd_q <= 1'b0;
      upd_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      delay1_q   <= delay1_d;
      delay2_q   <= delay2_d;
      width1_q   <= width1_d;
      width2_q   <= width2_d;
      pend_upd_q <= pend_upd_d;
      upd_done_q <= upd_done_d;
    end
  end

`ifdef PSCTRL_SCAN_EN
  // Scan engine registers.
  always_ff @(posedge clk40) begin
    if (reset) begin
      step_q      <= '0;
      saved_q     <= '0;
      first_q     <= '0;
      last_q      <= '0;
      dwell_q     <= '0;
      ch_q        <= 1'b0;
      pend_scan_q <= 1'b0;
      busy_q      <= 1'b0;
      step_rdy_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      step_q      <= step_d;
      saved_q     <= saved_d;
      first_q     <= first_d;
      last_q      <= last_d;
      dwell_q     <= dwell_d;
      ch_q        <= ch_d;
      pend_scan_q <= pend_scan_d;
      busy_q      <= busy_d;
      step_rdy_q  <= step_rdy_d;
      done_q      <= done_d;
    end
  end

  assign stepReady = step_rdy_q;
  assign scanBusy  = busy_q;
  assign scanDone  = done_q;
`else
  assign stepReady = 1'b0;
  assign scanBusy  = 1'b0;
  assign scanDone  = 1'b0;
`endif

  assign clockDelay1 = delay1_q;
  assign clockDelay2 = delay2_q;
  assign pulseWidth1 = width1_q;
  assign pulseWidth2 = width2_q;
  assign updateDone  = upd_done_q;

endmodule

// File: tb/tb_phase_shift_ctrl.sv
// tb_phase_shift_ctrl: directed/randomized bench for phase_shift_ctrl.
// Scan scenarios are exercised when PSCTRL_SCAN_EN is defined; otherwise the
// bench checks that the scan inputs are ignored.
module tb_phase_shift_ctrl;

  logic       clk40, reset;
  logic [4:0] cfgDelay1, cfgDelay2, cfgWidth1, cfgWidth2;
  logic       cfgUpdate, scanStart, scanAbort, scanChannel;
  logic [4:0] scanFirst, scanLast;
  logic [7:0] scanDwell;
  logic [4:0] clockDelay1, clockDelay2, pulseWidth1, pulseWidth2;
  logic       updateDone, stepReady, scanBusy, scanDone;
  logic [19:0] outs;

  int total = 0;
  int bad   = 0;
  // Expected settled drive: delay1, width1, delay2, width2.
  logic [4:0] mdl [4];

  phase_shift_ctrl #(.DWELL_W(8)) dut (
    .clk40       (clk40),
    .reset       (reset),
    .cfgDelay1   (cfgDelay1),
    .cfgDelay2   (cfgDelay2),
    .cfgWidth1   (cfgWidth1),
    .cfgWidth2   (cfgWidth2),
    .cfgUpdate   (cfgUpdate),
    .scanStart   (scanStart),
    .scanAbort   (scanAbort),
    .scanChannel (scanChannel),
    .scanFirst   (scanFirst),
    .scanLast    (scanLast),
    .scanDwell   (scanDwell),
    .clockDelay1 (clockDelay1),
    .clockDelay2 (clockDelay2),
    .pulseWidth1 (pulseWidth1),
    .pulseWidth2 (pulseWidth2),
    .updateDone  (updateDone),
    .stepReady   (stepReady),
    .scanBusy    (scanBusy),
    .scanDone    (scanDone)
  );

  assign outs = {clockDelay1, pulseWidth1, clockDelay2, pulseWidth2};

  initial begin
    clk40 = 1'b0;
    forever #5 clk40 = ~clk40;
  end

  task automatic tick();
    @(posedge clk40);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Update request (optionally alongside scanStart) and the k+1 / k+3 timing.
  task automatic do_update(input logic [4:0] v0, input logic [4:0] v1, input logic [4:0] v2,
                           input logic [4:0] v3, input bit with_scan);
    cfgDelay1 = v0; cfgWidth1 = v1; cfgDelay2 = v2; cfgWidth2 = v3;
    cfgUpdate = 1'b1;
    scanStart = with_scan;
    tick();
    cfgUpdate = 1'b0;
    scanStart = 1'b0;
    for (int t = 0; t <= 4; t++) begin
      chk($sformatf("upd_outs t=%0d", t), outs,
          (t == 0) ? {mdl[0], mdl[1], mdl[2], mdl[3]} : {v0, v1, v2, v3});
      chk($sformatf("upd_done t=%0d", t), updateDone, (t == 3));
      chk($sformatf("upd_busy t=%0d", t), {stepReady, scanBusy, scanDone}, 3'b000);
      if (t < 4) tick();
    end
    mdl[0] = v0; mdl[1] = v1; mdl[2] = v2; mdl[3] = v3;
  endtask

  // A second cfgUpdate during SETTLE is replayed, sampling cfg at the replay.
  task automatic settle_pend();
    logic [4:0] a [4];
    logic [4:0] b [4];
    logic [4:0] e [4];
    for (int i = 0; i < 4; i++) begin
      a[i] = 5'($urandom);
      b[i] = 5'($urandom);
    end
    cfgDelay1 = a[0]; cfgWidth1 = a[1]; cfgDelay2 = a[2]; cfgWidth2 = a[3];
    cfgUpdate = 1'b1;
    tick();
    cfgUpdate = 1'b0;
    for (int t = 0; t <= 7; t++) begin
      for (int i = 0; i < 4; i++) e[i] = (t == 0) ? mdl[i] : ((t >= 4) ? b[i] : a[i]);
      chk($sformatf("pend_outs t=%0d", t), outs, {e[0], e[1], e[2], e[3]});
      chk($sformatf("pend_done t=%0d", t), updateDone, (t == 3) || (t == 6));
      cfgUpdate = (t == 1);
      if (t == 1) begin
        cfgDelay1 = b[0]; cfgWidth1 = b[1]; cfgDelay2 = b[2]; cfgWidth2 = b[3];
      end
      if (t < 7) tick();
    end
    for (int i = 0; i < 4; i++) mdl[i] = b[i];
  endtask

`ifdef PSCTRL_SCAN_EN
  // One scan; expectations come from the step-count and per-step period rules.
  task automatic run_case(input int ch, input int first, input int n, input int dw,
                          input bit pre_upd, input bit mid, input bit do_abort);
    logic [4:0] o [4];
    logic [4:0] a [4];
    logic [4:0] b [4];
    logic [4:0] e [4];
    int d, p, off, a_t, endt, len, ts;
    bit exp_rdy, exp_busy, exp_done, exp_upd;
    d    = (dw == 0) ? 1 : dw;
    p    = 3 + d;
    off  = pre_upd ? 4 : 0;
    a_t  = p + 4 + int'($urandom_range(0, d - 1));
    endt = do_abort ? a_t + 1 : n * p + 1;
    len  = off + endt + (mid ? 4 : 2);
    for (int i = 0; i < 4; i++) begin
      o[i] = mdl[i];
      a[i] = 5'($urandom);
      b[i] = 5'($urandom);
    end
    scanChannel = ch[0];
    scanFirst   = 5'(first);
    scanLast    = 5'(first + n - 1);
    scanDwell   = 8'(dw);
    if (pre_upd) begin
      cfgDelay1 = a[0]; cfgWidth1 = a[1]; cfgDelay2 = a[2]; cfgWidth2 = a[3];
      cfgUpdate = 1'b1;
    end
    scanStart = 1'b1;
    tick();
    scanStart = 1'b0;
    cfgUpdate = 1'b0;
    for (int t = 0; t <= len; t++) begin
      ts = t - off;
      for (int i = 0; i < 4; i++) begin
        e[i] = o[i];
        if (pre_upd && t >= 1) e[i] = a[i];
        if (mid && t >= off + endt + 1) e[i] = b[i];
      end
      if (ts >= 1 && ts < endt) e[2 * ch] = 5'(first + (ts - 1) / p);
      exp_rdy  = (ts >= 3) && (ts < endt) && (((ts - 3) % p) == 0) && (((ts - 3) / p) < n);
      exp_busy = (ts >= 1) && (ts < endt);
      exp_done = (ts == endt);
      exp_upd  = (pre_upd && t == 3) || (mid && t == off + endt + 3);
      chk($sformatf("scan_outs ch=%0d f=%0d n=%0d t=%0d", ch, first, n, t), outs,
          {e[0], e[1], e[2], e[3]});
      chk($sformatf("scan_rdy t=%0d", t), stepReady, exp_rdy);
      chk($sformatf("scan_busy t=%0d", t), scanBusy, exp_busy);
      chk($sformatf("scan_done t=%0d", t), scanDone, exp_done);
      chk($sformatf("scan_upd t=%0d", t), updateDone, exp_upd);
      // Parameters are sampled at start only, so later changes must not matter.
      if (ts == 1) begin
        scanChannel = 1'($urandom);
        scanFirst   = 5'($urandom);
        scanLast    = 5'($urandom);
        scanDwell   = 8'($urandom);
      end
      cfgUpdate = mid && (ts + 1 == 2);
      if (mid && ts + 1 == 2) begin
        cfgDelay1 = a[0]; cfgWidth1 = a[1]; cfgDelay2 = a[2]; cfgWidth2 = a[3];
      end
      if (mid && t == off + endt) begin
        cfgDelay1 = b[0]; cfgWidth1 = b[1]; cfgDelay2 = b[2]; cfgWidth2 = b[3];
      end
      scanAbort = do_abort && (ts + 1 == a_t);
      if (t < len) tick();
    end
    cfgUpdate = 1'b0;
    scanAbort = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = mid ? b[i] : (pre_upd ? a[i] : o[i]);
  endtask
`endif

  initial begin
    reset = 1'b1;
    cfgDelay1 = '0; cfgDelay2 = '0; cfgWidth1 = '0; cfgWidth2 = '0;
    cfgUpdate = 1'b0; scanStart = 1'b0; scanAbort = 1'b0; scanChannel = 1'b0;
    scanFirst = '0; scanLast = '0; scanDwell = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_outs", outs, {5'd0, 5'd16, 5'd0, 5'd16});
    chk("rst_flags", {updateDone, stepReady, scanBusy, scanDone}, 4'b0000);
    mdl[0] = 5'd0; mdl[1] = 5'd16; mdl[2] = 5'd0; mdl[3] = 5'd16;

    do_update(5'd3, 5'd15, 5'd29, 5'd31, 1'b0);
    settle_pend();

`ifdef PSCTRL_SCAN_EN
    do_update(5'd7, 5'($urandom), 5'($urandom), 5'($urandom), 1'b0);
    run_case(0, 2, 3, 5, 1'b0, 1'b0, 1'b0);
    run_case(1, 30, 4, int'($urandom_range(0, 4)), 1'b0, 1'b0, 1'b0);
    run_case(int'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1, 0, 1'b0, 1'b0, 1'b0);
    run_case(int'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 3, 2, 1'b0, 1'b0, 1'b1);
    run_case(int'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 2, 1, 1'b0, 1'b1, 1'b0);
    run_case(int'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 2, 3, 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 8; r++) begin
      int mode;
      mode = int'($urandom_range(0, 3));
      run_case(int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
               int'($urandom_range(2, 6)), int'($urandom_range(0, 5)),
               mode == 1, mode == 2, mode == 3);
    end

    // Reset while dwelling: defaults next cycle and no scanDone afterwards.
    scanChannel = 1'($urandom);
    scanFirst   = 5'($urandom);
    scanLast    = scanFirst + 5'd2;
    scanDwell   = 8'd4;
    scanStart   = 1'b1;
    tick();
    scanStart = 1'b0;
    repeat (4) tick();
    chk("pre_rst_busy", scanBusy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int t = 0; t < 6; t++) begin
      chk($sformatf("mid_rst_outs t=%0d", t), outs, {5'd0, 5'd16, 5'd0, 5'd16});
      chk($sformatf("mid_rst_flags t=%0d", t), {stepReady, scanBusy, scanDone}, 3'b000);
      tick();
    end
    mdl[0] = 5'd0; mdl[1] = 5'd16; mdl[2] = 5'd0; mdl[3] = 5'd16;
    do_update(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'b0);
`else
    // Scan requests must leave the outputs and flags alone.
    scanFirst = 5'($urandom);
    scanLast  = 5'($urandom);
    scanDwell = 8'($urandom);
    for (int t = 0; t < 12; t++) begin
      scanStart   = (t % 3 == 0);
      scanAbort   = (t % 5 == 4);
      scanChannel = 1'($urandom);
      tick();
      chk($sformatf("noscan_outs t=%0d", t), outs, {mdl[0], mdl[1], mdl[2], mdl[3]});
      chk($sformatf("noscan_flags t=%0d", t), {stepReady, scanBusy, scanDone}, 3'b000);
    end
    scanStart = 1'b0;
    scanAbort = 1'b0;
    do_update(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'b1);
    for (int t = 0; t < 10; t++) begin
      tick();
      chk($sformatf("post_outs t=%0d", t), outs, {mdl[0], mdl[1], mdl[2], mdl[3]});
      chk($sformatf("post_flags t=%0d", t), {updateDone, stepReady, scanBusy, scanDone}, 4'b0000);
    end
`endif

    do_update(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
